result_tx_formatter: RTL and testbench
======================================

# result_tx_formatter

Transmit-side host interface for the UART ALU: captures an ALU result, converts it to unsigned ASCII decimal, and pushes the characters, followed by a terminator, into the UART TX FIFO. It is the counterpart of the receive-side parser that turns ASCII operands and operators from the RX FIFO into ALU register loads. It sits between the ALU result register and the TX FIFO write port.

## Interface
Parameters:
- NBIT, 8: result width and FIFO data width.
- NDIG, 3: BCD digit count. Must satisfy 10^NDIG > 2^NBIT − 1.
- TERM, 8'h0A: terminator character written after the last digit.

Ports:
- CLK  in  1  system clock. All state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- result_valid  in  1  one-cycle strobe: `result` is valid.
- result  in  NBIT  ALU result, unsigned.
- FIFO_full  in  1  TX FIFO full. No write may occur while it is high.
- data_out  out  NBIT  character to the FIFO. Valid whenever WR_FIFO=1.
- WR_FIFO  out  1  FIFO write strobe. One character per cycle high.
- BUSY  out  1  high from the capture edge until the return to IDLE.
- DROP  out  1  one-cycle pulse: a result_valid was ignored while BUSY.
- STATE  out  2  current state, for debug.

## Operation
- States: IDLE=2'b00, CONV=2'b01, SEND=2'b10, TERMS=2'b11.
- **IDLE**
  - On result_valid: load the shift register with `result`, clear the BCD register, set bit counter = NBIT, go to CONV.
- **CONV**
  - Double-dabble conversion, one bit per cycle.
  - Each cycle:
    - add 3 to every BCD nibble ≥ 5;
    - shift {BCD, shift register} left by 1;
    - decrement the bit counter.
  - After exactly NBIT cycles:
    - set digit index = position of the highest nonzero BCD nibble (0 if all digits are zero);
    - go to SEND.
- **SEND**
  - data_out = 8'h30 + BCD[index].
  - WR_FIFO = ~FIFO_full, combinational from state and FIFO_full.
  - On a write cycle: if index==0 go to TERMS, else decrement index.
  - While FIFO_full: hold the state and index. data_out remains stable.
- **TERMS**
  - data_out = TERM. WR_FIFO = ~FIFO_full.
  - On a write: go to IDLE.
- Leading zeros are suppressed. Result 0 emits the single character "0".
- BUSY = (state != IDLE).
- DROP is a registered pulse, set when result_valid=1 in any state other than IDLE.
  - A result_valid arriving in the same cycle as the final TERMS write is dropped; the block captures only in IDLE.
- Arithmetic:
  - BCD register is 4·NDIG bits.
  - ASCII conversion uses an NBIT-wide add of 8'h30 to the zero-extended nibble.
- data_out in IDLE and CONV = 0. WR_FIFO in IDLE and CONV = 0.

## Timing
- Reset values:
  - state=IDLE, BCD=0, shift register=0, index=0;
  - data_out=0, WR_FIFO=0, BUSY=0, DROP=0, STATE=2'b00.
- RESET mid-operation aborts immediately. WR_FIFO falls asynchronously with the state. A partial string is not resumed.
- Capture: result_valid sampled high in IDLE at edge 0. BUSY=1 from cycle 1.
- CONV occupies cycles 1..NBIT.
- With FIFO never full:
  - first WR_FIFO in cycle NBIT+1;
  - k digits occupy cycles NBIT+1 .. NBIT+k;
  - terminator in cycle NBIT+k+1;
  - IDLE (BUSY=0) from cycle NBIT+k+2.
- Each cycle with FIFO_full=1 during SEND or TERMS adds exactly one cycle of latency.
- FIFO_full changing mid-cycle affects WR_FIFO combinationally. The write commits only on an edge where WR_FIFO=1.

## Test plan
- **result=8'd255, FIFO_full=0**
  - WR_FIFO high in cycles 9,10,11,12 with data_out 8'h32, 8'h35, 8'h35, 8'h0A;
  - BUSY low in cycle 13.
- **result=0**
  - exactly two writes: 8'h30 in cycle 9, then 8'h0A in cycle 10;
  - no other WR_FIFO pulses.
- **result=8'd7, then result=8'd40 after IDLE**
  - "7\n" (8'h37, 8'h0A), then "40\n" (8'h34, 8'h30, 8'h0A);
  - no leading 8'h30.
- **result=8'd128, FIFO_full high for cycles 10–12**
  - 8'h31 written in cycle 9;
  - 8'h32 held on data_out with WR_FIFO=0 through cycle 12, written in cycle 13;
  - 8'h38 written in cycle 14, 8'h0A in cycle 15.
- **result_valid pulsed in cycle 4 while converting result=8'd99**
  - DROP=1 in cycle 5;
  - output is still "99\n".
- **RESET asserted in cycle 10 during SEND of 8'd200**
  - WR_FIFO=0 and STATE=2'b00 immediately;
  - a new result_valid with 8'd5 after reset release produces "5\n" only.

Source files
------------

// File: rtl/result_tx_formatter.sv
// Converts an unsigned ALU result to ASCII decimal with double-dabble and
// streams the digits, then a terminator, into the TX FIFO write port.
module result_tx_formatter #(
  parameter int              NBIT = 8,
  parameter int              NDIG = 3,
  parameter logic [NBIT-1:0] TERM = NBIT'(8'h0A)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            result_valid,
  input  logic [NBIT-1:0] result,
  input  logic            FIFO_full,
  output logic [NBIT-1:0] data_out,
  output logic            WR_FIFO,
  output logic            BUSY,
  output logic            DROP,
  output logic [1:0]      STATE
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(NBIT + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CONV  = 2'b01,
    SEND  = 2'b10,
    TERMS = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [NBIT-1:0] shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            drop_q, drop_d;

  logic [BW-1:0]      bcd_adj;
  logic [BW+NBIT-1:0] cat_sh;
  logic [IW-1:0]      hi_idx;
  logic [3:0]         cur_nib;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    drop_d   = result_valid && (state_q != IDLE);
    data_out = '0;
    WR_FIFO  = 1'b0;

    // One double-dabble step: correct nibbles >= 5, then shift the pair left.
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    cat_sh = {bcd_adj, shift_q} << 1;

    // Most significant nonzero digit of the finished value; 0 for a zero result.
    hi_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cat_sh[NBIT + 4*i +: 4] != 4'd0) hi_idx = IW'(i);
    end

    cur_nib = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) cur_nib = bcd_q[4*i +: 4];
    end

    case (state_q)
      IDLE: begin
        if (result_valid) begin
          shift_d = result;
          bcd_d   = '0;
          cnt_d   = CW'(NBIT);
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = cat_sh[BW+NBIT-1:NBIT];
        shift_d = cat_sh[NBIT-1:0];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          idx_d   = hi_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        data_out = NBIT'(8'h30) + NBIT'(cur_nib);
        WR_FIFO  = ~FIFO_full;
        if (!FIFO_full) begin
          if (idx_q == '0) state_d = TERMS;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      TERMS: begin
        data_out = TERM;
        WR_FIFO  = ~FIFO_full;
        if (!FIFO_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY  = (state_q != IDLE);
  assign DROP  = drop_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_result_tx_formatter.sv
// Bench for result_tx_formatter: decimal-string reference model feeds an
// expected-character queue; a negedge monitor checks every FIFO write.
module tb_result_tx_formatter;

  localparam int         NBIT = 8;
  localparam int         NDIG = 3;
  localparam logic [7:0] TERM = 8'h0A;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  logic            valid_main = 1'b0;
  logic            valid_extra = 1'b0;
  logic            result_valid;
  logic [NBIT-1:0] result = '0;
  logic            FIFO_full = 1'b0;
  logic [NBIT-1:0] data_out;
  logic            WR_FIFO;
  logic            BUSY;
  logic            DROP;
  logic [1:0]      STATE;

  assign result_valid = valid_main | valid_extra;

  result_tx_formatter #(.NBIT(NBIT), .NDIG(NDIG), .TERM(TERM)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .result_valid (result_valid),
    .result       (result),
    .FIFO_full    (FIFO_full),
    .data_out     (data_out),
    .WR_FIFO      (WR_FIFO),
    .BUSY         (BUSY),
    .DROP         (DROP),
    .STATE        (STATE)
  );

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // cycle numbering: cycle 1 follows the capture edge
  int          cap = -1000;
  logic [63:0] full_mask = '0;
  int          drop_at = 0;

  logic [NBIT-1:0] exp_q[$];
  int              got_cyc[$];
  int              n_vec = 0;
  int              n_err = 0;

  function automatic int cyc_now();
    return edge_cnt - cap + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle driver for back-pressure and stray result_valid pulses
  always @(posedge CLK) begin : cyc_drv
    int c;
    #1;
    c = cyc_now();
    FIFO_full   = (c >= 1 && c <= 63) ? full_mask[c[5:0]] : 1'b0;
    valid_extra = (drop_at > 0 && c == drop_at);
  end

  // monitor / scoreboard
  always @(negedge CLK) begin : mon
    int c;
    c = cyc_now();
    if (WR_FIFO) begin
      check("no_write_when_full", 32'(FIFO_full), 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got %0h expected no write", data_out);
      end else begin
        check("char", 32'(data_out), 32'(exp_q.pop_front()));
      end
      got_cyc.push_back(c);
    end else if (!BUSY) begin
      check("data_out_idle", 32'(data_out), 32'd0);
    end else if (c >= 1 && c <= NBIT) begin
      check("data_out_conv", 32'(data_out), 32'd0);
    end else if (FIFO_full && exp_q.size() > 0) begin
      check("data_out_hold", 32'(data_out), 32'(exp_q[0]));
    end
  end

  // driver: one result, reference string + write schedule from plain arithmetic
  task automatic run_txn(input logic [7:0] v, input logic [63:0] mask, input int d_at);
    int         n;
    logic [7:0] chars[$];
    int         exp_cyc[$];
    int         c;
    int         end_c;
    int         cyc;
    bit         done;

    n = int'(v);
    do begin
      chars.push_front(8'h30 + 8'(n % 10));
      n = n / 10;
    end while (n > 0);
    chars.push_back(TERM);

    c = NBIT + 1;
    foreach (chars[i]) begin
      while (c <= 63 && mask[c]) c++;
      exp_cyc.push_back(c);
      c++;
    end
    end_c = c;

    foreach (chars[i]) exp_q.push_back(chars[i]);
    got_cyc.delete();

    @(negedge CLK);
    cap        = edge_cnt + 1;
    full_mask  = mask;
    drop_at    = d_at;
    result     = v;
    valid_main = 1'b1;
    @(negedge CLK);
    valid_main = 1'b0;
    check("busy_cycle1", 32'(BUSY), 32'd1);
    check("state_cycle1", 32'(STATE), 32'd1);

    cyc  = 1;
    done = 1'b0;
    while (!done) begin
      check("drop", 32'(DROP), 32'((d_at > 0) && (cyc == d_at + 1)));
      if (!BUSY) begin
        done = 1'b1;
      end else if (cyc > 250) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: BUSY still 1 at cycle %0d, expected 0 by cycle %0d", cyc, end_c);
        done = 1'b1;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end

    check("busy_low_cycle", 32'(cyc), 32'(end_c));
    check("write_count", 32'(got_cyc.size()), 32'(exp_cyc.size()));
    foreach (exp_cyc[i]) begin
      if (i < got_cyc.size()) check("write_cycle", 32'(got_cyc[i]), 32'(exp_cyc[i]));
    end
    check("chars_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    full_mask = '0;
    drop_at   = 0;
  endtask

  logic [63:0] m;
  int          d;

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_wr", 32'(WR_FIFO), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_drop", 32'(DROP), 32'd0);
    check("rst_state", 32'(STATE), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_state", 32'(STATE), 32'd0);

    run_txn(8'd255, 64'd0, 0);
    run_txn(8'd0, 64'd0, 0);
    run_txn(8'd7, 64'd0, 0);
    run_txn(8'd40, 64'd0, 0);
    m = '0;
    m[10] = 1'b1; m[11] = 1'b1; m[12] = 1'b1;
    run_txn(8'd128, m, 0);
    run_txn(8'd99, 64'd0, 4);
    run_txn(8'd7, 64'd0, 10);   // stray valid on the terminator write cycle

    // reset mid-SEND: "2" goes out in cycle 9, reset early in cycle 10
    got_cyc.delete();
    exp_q.push_back(8'h32);
    @(negedge CLK);
    cap        = edge_cnt + 1;
    full_mask  = '0;
    drop_at    = 0;
    result     = 8'd200;
    valid_main = 1'b1;
    @(negedge CLK);
    valid_main = 1'b0;
    repeat (8) @(negedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("abort_wr", 32'(WR_FIFO), 32'd0);
    check("abort_state", 32'(STATE), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_sent_first", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    run_txn(8'd5, 64'd0, 0);

    for (int k = 0; k < 25; k++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom};
      d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NBIT + 2)) : 0;
      run_txn(8'($urandom_range(0, 255)), m, d);
    end

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
